gray_counter: RTL and testbench

//  Parametrised synchronous up/down counter that keeps binary and Gray-code

---
 rtl/gray_counter.sv | 105 ++++++++++
 tb/tb_gray_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_counter.sv
// Up/down counter that keeps a binary count and its Gray-coded image in lockstep,
// with wrap or saturate limits, synchronous clear and binary/Gray load.
module gray_counter #(
  parameter int BW_DATA  = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic               i_load_gray,
  input  logic [BW_DATA-1:0] i_load_data,
  input  logic               i_en,
  input  logic               i_dn,
  output logic [BW_DATA-1:0] o_bin,
  output logic [BW_DATA-1:0] o_gray,
  output logic               o_tc
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  function automatic logic [BW_DATA-1:0] bin2gray(input logic [BW_DATA-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [BW_DATA-1:0] gray2bin(input logic [BW_DATA-1:0] g);
    logic [BW_DATA-1:0] b;
    b[BW_DATA-1] = g[BW_DATA-1];
    for (int k = BW_DATA - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  op_e                op;
  logic [BW_DATA-1:0] load_bin;
  logic [BW_DATA-1:0] bin_nxt;
  logic               tc_nxt;
  logic               at_max;
  logic               at_zero;

  assign at_max   = &o_bin;
  assign at_zero  = ~|o_bin;
  assign load_bin = i_load_gray ? gray2bin(i_load_data) : i_load_data;

  // Control priority: clear beats load beats count.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    op = OP_HOLD;
    if (i_clr)       op = OP_CLR;
    else if (i_load) op = OP_LOAD;
    else if (i_en)   op = i_dn ? OP_DOWN : OP_UP;
  end

  always_comb begin
    bin_nxt = o_bin;
    tc_nxt  = 1'b0;
    unique case (op)
      OP_CLR:  bin_nxt = '0;
      OP_LOAD: bin_nxt = load_bin;
      OP_UP: begin
        if (at_max) begin
          tc_nxt  = 1'b1;
          bin_nxt = SATURATE ? o_bin : '0;
        end else begin
          bin_nxt = o_bin + BW_DATA'(1);
        end
      end
      OP_DOWN: begin
        if (at_zero) begin
          tc_nxt  = 1'b1;
          bin_nxt = SATURATE ? o_bin : '1;
        end else begin
          bin_nxt = o_bin - BW_DATA'(1);
        end
      end
      default: bin_nxt = o_bin;
    endcase
  end

  // The Gray register is loaded from the same next-state value as the binary one,
  // so the pair can never be observed out of step.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (i_rst) begin
      o_bin  <= '0;
      o_gray <= '0;
      o_tc   <= 1'b0;
    end else begin
      o_bin  <= bin_nxt;
      o_gray <= bin2gray(bin_nxt);
      o_tc   <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench: directed scenarios on 4-bit wrap/saturate counters and a
// randomized sweep on 8-bit wrap/saturate counters against an arithmetic model.
module tb_gray_counter;

  typedef struct {
    bit clr;
    bit load;
    bit lg;
    int data;
    bit en;
    bit dn;
  } ctl_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  ctl_t ctl4  = '{0, 0, 0, 0, 0, 0};
  ctl_t ctl8  = '{0, 0, 0, 0, 0, 0};

  logic [3:0] b0, g0, b1, g1;
  logic [7:0] b2, g2, b3, g3;
  logic       t0, t1, t2, t3;

  logic [7:0] obin[4];
  logic [7:0] ogray[4];
  logic       otc[4];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state for DUTs: 0 = 4-bit wrap, 1 = 4-bit sat, 2 = 8-bit wrap, 3 = 8-bit sat.
  int mb[4];
  bit mt[4];
  int w_of[4]   = '{4, 4, 8, 8};
  bit sat_of[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  always #5 i_clk = ~i_clk;

  gray_counter #(.BW_DATA(4), .SATURATE(1'b0)) u_w4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(ctl4.clr), .i_load(ctl4.load),
    .i_load_gray(ctl4.lg), .i_load_data(ctl4.data[3:0]), .i_en(ctl4.en), .i_dn(ctl4.dn),
    .o_bin(b0), .o_gray(g0), .o_tc(t0));

  gray_counter #(.BW_DATA(4), .SATURATE(1'b1)) u_s4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(ctl4.clr), .i_load(ctl4.load),
    .i_load_gray(ctl4.lg), .i_load_data(ctl4.data[3:0]), .i_en(ctl4.en), .i_dn(ctl4.dn),
    .o_bin(b1), .o_gray(g1), .o_tc(t1));

  gray_counter #(.BW_DATA(8), .SATURATE(1'b0)) u_w8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(ctl8.clr), .i_load(ctl8.load),
    .i_load_gray(ctl8.lg), .i_load_data(ctl8.data[7:0]), .i_en(ctl8.en), .i_dn(ctl8.dn),
    .o_bin(b2), .o_gray(g2), .o_tc(t2));

  gray_counter #(.BW_DATA(8), .SATURATE(1'b1)) u_s8 (
    .i_clk(i_clk), .i_rst(i_rst), .i_clr(ctl8.clr), .i_load(ctl8.load),
    .i_load_gray(ctl8.lg), .i_load_data(ctl8.data[7:0]), .i_en(ctl8.en), .i_dn(ctl8.dn),
    .o_bin(b3), .o_gray(g3), .o_tc(t3));

  always_comb begin
    obin[0] = {4'h0, b0}; ogray[0] = {4'h0, g0}; otc[0] = t0;
    obin[1] = {4'h0, b1}; ogray[1] = {4'h0, g1}; otc[1] = t1;
    obin[2] = b2;         ogray[2] = g2;         otc[2] = t2;
    obin[3] = b3;         ogray[3] = g3;         otc[3] = t3;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Gray decode by exhaustive search: the binary value whose Gray image matches.
  function automatic int gray_decode(input int g, input int w);
    for (int c = 0; c < (1 << w); c++) begin
      if ((c ^ (c >> 1)) == g) return c;
    end
    return 0;
  endfunction

  task automatic model_step(input int i, input ctl_t c);
    int max_v;
    int d;
    max_v = (1 << w_of[i]) - 1;
    d     = c.data & max_v;
    mt[i] = 1'b0;
    if (c.clr) begin
      mb[i] = 0;
    end else if (c.load) begin
      mb[i] = c.lg ? gray_decode(d, w_of[i]) : d;
    end else if (c.en && !c.dn) begin
      if (mb[i] == max_v) begin
        mt[i] = 1'b1;
        mb[i] = sat_of[i] ? max_v : 0;
      end else begin
        mb[i] = mb[i] + 1;
      end
    end else if (c.en && c.dn) begin
      if (mb[i] == 0) begin
        mt[i] = 1'b1;
        mb[i] = sat_of[i] ? 0 : max_v;
      end else begin
        mb[i] = mb[i] - 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mb[i] = 0;
      mt[i] = 1'b0;
    end
  endtask

  // One clock edge with the currently driven controls, then compare every DUT.
  task automatic step();
    logic [7:0] pg[4];
    int         pb[4];
    ctl_t       c;
    for (int i = 0; i < 4; i++) begin
      pg[i] = ogray[i];
      pb[i] = mb[i];
    end
    @(posedge i_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      c = (i < 2) ? ctl4 : ctl8;
      model_step(i, c);
      check($sformatf("bin[%0d]", i), 32'(obin[i]), mb[i]);
      check($sformatf("gray[%0d]", i), 32'(ogray[i]), mb[i] ^ (mb[i] >> 1));
      check($sformatf("tc[%0d]", i), 32'(otc[i]), 32'(mt[i]));
      if (c.en && !c.clr && !c.load && mb[i] != pb[i])
        check($sformatf("onebit[%0d]", i), $countones(pg[i] ^ ogray[i]), 1);
    end
  endtask

  task automatic set4(input bit clr, input bit load, input bit lg, input int data,
                      input bit en, input bit dn);
    ctl4 = '{clr, load, lg, data, en, dn};
  endtask

  initial begin
    model_reset();
    i_rst = 1'b1;
    #12;
    for (int i = 0; i < 4; i++) begin
      check("rst_bin", 32'(obin[i]), 0);
      check("rst_tc", 32'(otc[i]), 0);
    end
    @(negedge i_clk);
    i_rst = 1'b0;

    // Scenario 1: asynchronous reset in the middle of a cycle.
    set4(0, 1, 0, 4, 0, 0); step();
    set4(0, 0, 0, 0, 1, 0); step();
    check("pre_rst_bin", 32'(b0), 5);
    #3;
    i_rst = 1'b1;
    #1;
    model_reset();
    check("async_rst_bin", 32'(b0), 0);
    check("async_rst_gray", 32'(g0), 0);
    check("async_rst_bin_s", 32'(b1), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    step(); check("s1_bin1", 32'(b0), 1); check("s1_gray1", 32'(g0), 1);
    step(); check("s1_bin2", 32'(b0), 2); check("s1_gray2", 32'(g0), 3);
    step(); check("s1_bin3", 32'(b0), 3); check("s1_gray3", 32'(g0), 2);

    // Hold with no control asserted.
    set4(0, 0, 0, 0, 0, 1); step();
    check("hold_bin", 32'(b0), 3); check("hold_tc", 32'(t0), 0);

    // Scenario 2: wrap at MAX.
    set4(0, 1, 0, 14, 0, 0); step();
    set4(0, 0, 0, 0, 1, 0);
    step(); check("s2_bin15", 32'(b0), 15); check("s2_tc15", 32'(t0), 0);
    check("s2_gray15", 32'(g0), 8);
    step(); check("s2_bin0", 32'(b0), 0); check("s2_tc0", 32'(t0), 1);
    check("s2_gray0", 32'(g0), 0);
    step(); check("s2_bin1", 32'(b0), 1); check("s2_tc1", 32'(t0), 0);

    // Scenario 3: saturate at zero, then leave the limit.
    set4(0, 1, 0, 1, 0, 0); step();
    set4(0, 0, 0, 0, 1, 1);
    step(); check("s3_bin_a", 32'(b1), 0); check("s3_tc_a", 32'(t1), 0);
    step(); check("s3_bin_b", 32'(b1), 0); check("s3_tc_b", 32'(t1), 1);
    step(); check("s3_bin_c", 32'(b1), 0); check("s3_tc_c", 32'(t1), 1);
    set4(0, 0, 0, 0, 1, 0);
    step(); check("s3_bin_up", 32'(b1), 1); check("s3_tc_up", 32'(t1), 0);

    // Scenario 4: Gray load, then Gray load overridden by clear.
    set4(0, 1, 1, 13, 0, 0); step();
    check("s4_bin", 32'(b0), 9); check("s4_gray", 32'(g0), 13);
    set4(1, 1, 1, 13, 1, 0); step();
    check("s4_clr_bin", 32'(b0), 0); check("s4_clr_gray", 32'(g0), 0);

    // Scenario 5: randomized sweep on all counters.
    for (int n = 0; n < 1000; n++) begin
      ctl_t c;
      int   r;
      int   sel;
      r      = int'($urandom_range(0, 99));
      c.clr  = (r < 3);
      c.load = (r >= 3 && r < 12);
      c.lg   = $urandom_range(0, 1) == 1;
      sel    = int'($urandom_range(0, 4));
      c.data = (sel == 0) ? 0 : (sel == 1) ? 255 : (sel == 2) ? 1 :
               (sel == 3) ? 254 : int'($urandom_range(0, 255));
      c.en   = $urandom_range(0, 9) < 8;
      c.dn   = (n % 200) < 100 ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      ctl8   = c;
      ctl4   = c;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
